// File: rtl/fft_arith_pkg.sv
// fft_arith_pkg: shared widths, pipeline depth and saturation helpers for the FFT datapath.
// Width helpers are functions because the datapath widths follow each block's SIZE parameter.
package fft_arith_pkg;

    localparam int MULT_STAGES = 3;

    function automatic int mag_w(input int size);
        return size;
    endfunction

    function automatic int prod_w(input int size);
        return 2 * size;
    endfunction

    // A negative result can reach one count further than a positive one.
    function automatic logic [63:0] sat_limit(input logic neg, input int size);
        return neg ? (64'd1 << (size - 1)) : (64'd1 << (size - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] round_half(input int frac);
        return 64'd1 << (frac - 1);
    endfunction

endpackage

// File: rtl/sign_mag_mult_pipe_mag_split.sv
// mag_split: combinational split of a two's-complement value into unsigned magnitude and sign.
// The most negative input maps to magnitude 2^(SIZE-1), which still fits in SIZE unsigned bits.
module mag_split #(
    parameter int SIZE = 8
) (
    input  logic [SIZE-1:0] x,
    output logic [SIZE-1:0] mag,
    output logic            neg
);

    assign neg = x[SIZE-1];
    assign mag = neg ? -x : x;

endmodule

// File: rtl/sign_mag_mult_pipe.sv
// sign_mag_mult_pipe: 3-stage sign/magnitude multiplier with saturation and valid/ready handshake.
// Define SIGN_MAG_ROUND_EN to round half away from zero instead of truncating the magnitude.
module sign_mag_mult_pipe
    import fft_arith_pkg::*;
#(
    parameter int SIZE = 8,
    parameter int FRAC = 7
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] in_a,
    input  logic [SIZE-1:0] in_b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic            out_sat
);

    localparam int MW = mag_w(SIZE);
    localparam int PW = prod_w(SIZE);

    logic [MW-1:0] ma, mb, mag_a, mag_b;
    logic          na, nb, s1, s2;
    logic          v1, v2, v3, ld1, ld2, ld3;
    logic [PW-1:0] p, m_raw, lim, m;
    logic [SIZE-1:0] res;
    logic          sat;

    mag_split #(.SIZE(SIZE)) u_split_a (.x(in_a), .mag(ma), .neg(na));
    mag_split #(.SIZE(SIZE)) u_split_b (.x(in_b), .mag(mb), .neg(nb));

    // Each stage loads when empty or when its successor moves on, so bubbles collapse.
    assign ld3       = !v3 || out_ready;
    assign ld2       = !v2 || ld3;
    assign ld1       = !v1 || ld2;
    assign in_ready  = ld1;
    assign out_valid = v3;

`ifdef SIGN_MAG_ROUND_EN
    assign m_raw = (p + PW'(round_half(FRAC))) >> FRAC;
`else
    assign m_raw = p >> FRAC;
`endif
    assign lim = PW'(sat_limit(s2, SIZE));
    assign sat = m_raw > lim;
    assign m   = sat ? lim : m_raw;
    assign res = SIZE'(s2 ? -m : m);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1       <= 1'b0;
            v2       <= 1'b0;
            v3       <= 1'b0;
            mag_a    <= '0;
            mag_b    <= '0;
            s1       <= 1'b0;
            s2       <= 1'b0;
            p        <= '0;
            out_data <= '0;
            out_sat  <= 1'b0;
        end else begin
            if (ld1) v1 <= in_valid;
            if (ld1 && in_valid) begin
                mag_a <= ma;
                mag_b <= mb;
                s1    <= na ^ nb;
            end
            if (ld2) v2 <= v1;
            if (ld2 && v1) begin
                p  <= PW'(mag_a) * PW'(mag_b);
                s2 <= s1;
            end
            if (ld3) v3 <= v2;
            if (ld3 && v2) begin
                out_data <= res;
                out_sat  <= sat;
            end
        end
    end

endmodule

// File: doc/sign_mag_mult_pipe.md
# sign_mag_mult_pipe

Pipelined, parametrised signed multiplier for the FFT butterfly datapath. It splits each two's-complement operand into magnitude and sign, multiplies the magnitudes unsigned, then rescales, saturates and restores the sign. A valid/ready handshake with per-stage bubble collapsing sits on both sides, so the block can drop in between the twiddle ROM and the butterfly adder without external stall logic.

## Interface
- SIZE, 8: width of both operands and of the result (two's complement).
- FRAC, 7: fractional bits of operand b (twiddle, Q1.FRAC); must satisfy 1 ≤ FRAC ≤ SIZE-1.
- clk  in  1  rising-edge clock; the block has one clock.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  a/b present.
- in_ready  out  1  block accepts a/b this cycle.
- in_a  in  SIZE  sample, two's complement.
- in_b  in  SIZE  coefficient, two's complement Q1.FRAC.
- out_valid  out  1  out_data valid.
- out_ready  in  1  downstream accepts.
- out_data  out  SIZE  result, two's complement.
- out_sat  out  1  result was clipped; qualified by out_valid.

## Operation
- Stage S1 (split): mag_x = x[SIZE-1] ? (~x+1) : x, taken as an unsigned SIZE-bit value. -2^(SIZE-1) therefore gives magnitude 2^(SIZE-1) with no loss. Sign s = a[SIZE-1] ^ b[SIZE-1].
- Stage S2 (multiply): P = mag_a * mag_b, unsigned, 2·SIZE bits. Maximum value is 2^(2·SIZE-2).
- Stage S3 (scale/clip/merge):
  - M = P >> FRAC (truncation toward zero), or the rounded form under ROUND_EN.
  - Positive limit L = 2^(SIZE-1)-1 when s=0; 2^(SIZE-1) when s=1.
  - If M > L, then M = L and sat = 1.
  - out_data = s ? (~M+1) : M, truncated to SIZE bits.
  - M = 0 always yields out_data = 0, whatever the value of s.
- Handshake:
  - Stage k loads when !valid_k or stage k+1 loads; S3 is "consumed" when out_ready is high.
  - in_ready = !valid_S1 | S1 advances.
  - A transfer occurs when valid and ready are both high. Data and order are preserved.
  - Holding out_valid: out_data and out_sat stay stable until consumed.
  - in_a/in_b are ignored when in_valid is low.
- Bubbles collapse: an empty stage never blocks a later one from being refilled.

## Timing
- Reset (async assert, sync-safe release): all stage valids are 0, out_valid=0, out_data=0, out_sat=0, in_ready=1 on the first cycle after release.
- Latency is 3 cycles from an in_valid&in_ready edge to out_valid, with out_ready held high.
- Throughput is 1 result/cycle with no backpressure.
- Capacity is 3 in-flight results. When out_ready is low and all stages are full, in_ready drops combinationally in the same cycle.
- When out_ready is low and a later stage is empty, an input is still accepted until the pipeline is full.
- Simultaneous consume at S3 and accept at S1 in the same cycle is lossless.
- rst_n asserted mid-operation discards all in-flight data immediately; no partial output appears after release.

## Configuration
- SIGN_MAG_ROUND_EN defined: M = (P + 2^(FRAC-1)) >> FRAC, which is round-half-away-from-zero because it operates on the magnitude. Saturation is checked after rounding.
- Undefined: pure truncation of the magnitude, i.e. round toward zero.
- Latency and handshake are identical in both builds.

## Structure
- Shared package fft_arith_pkg:
  - MAG_W = SIZE, PROD_W = 2·SIZE.
  - Pipeline depth constant MULT_STAGES = 3.
  - Saturation-limit helper functions.
- Sub-module mag_split (SIZE): combinational magnitude/sign split, instantiated twice in S1.
- The handshake and stage registers stay in the top module.

## Test plan
- SIZE=8, FRAC=7, a=64, b=64 -> out_data=32, out_sat=0, out_valid exactly 3 cycles after accept.
- a=-128, b=-128 -> M=128 > 127, so out_data=127, out_sat=1.
- a=-128, b=127 -> 16256>>7=127, so out_data=-127 (0x81), out_sat=0. Also a=-128, b=-128 with sign flipped via b=… : a=128 impossible, so use a=-128, b=64 -> out_data=-64, out_sat=0.
- a=3, b=64 (1.5):
  - With SIGN_MAG_ROUND_EN -> 2.
  - Without -> 1.
  - a=-3 gives -2 and -1 respectively.
  - a=0, b=-128 -> 0 in both builds.
- Stream 10 incrementing inputs, out_ready low for cycles 4-8:
  - in_ready drops once 3 entries are held.
  - Outputs are complete, in order, and stable while stalled.
  - After release, full rate resumes with no duplicates.
- Assert rst_n low with 3 results in flight, then release:
  - out_valid=0, out_data=0, in_ready=1.
  - No stale result ever appears.
